// File: rtl/sparc_ifu_fill_waysel.sv
// Icache fill-way allocator: picks a victim way per miss (invalid way first, else LFSR way),
// never a way reserved by another thread's pending fill to the same set, and holds it until the fill returns.

module sparc_ifu_fill_waysel_rsv #(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  logic [1:0]       set_way_i,
    input  logic             qry_en_i,
    input  logic [IDX_W-1:0] qry_idx_i,
    output logic             busy_o,
    output logic [3:0]       blk_o
);
    typedef struct packed {
        logic             busy;
        logic [IDX_W-1:0] idx;
        logic [1:0]       way;
    } rsv_t;

    rsv_t rsv_q, rsv_d;

    always_comb begin
        rsv_d = rsv_q;
        if (set_i) begin
            rsv_d.busy = 1'b1;
            rsv_d.idx  = set_idx_i;
            rsv_d.way  = set_way_i;
        end else if (clr_i) begin
            rsv_d.busy = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rsv_q <= '0;
        else       rsv_q <= rsv_d;
    end

    // An entry being released this cycle no longer blocks anyone.
    always_comb begin
        blk_o = '0;
        if (qry_en_i && rsv_q.busy && !clr_i && (rsv_q.idx == qry_idx_i))
            blk_o[rsv_q.way] = 1'b1;
    end

    assign busy_o = rsv_q.busy;
endmodule

module sparc_ifu_fill_waysel #(
    parameter int NTHR  = 4,
    parameter int IDX_W = 7,
    parameter int NWAYS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       rand_way_i,
    output logic             lfsr_advance_o,
    input  logic             alloc_req_i,
    input  logic [1:0]       alloc_tid_i,
    input  logic [IDX_W-1:0] alloc_idx_i,
    input  logic [3:0]       set_vld_i,
    input  logic             fill_done_i,
    input  logic [1:0]       fill_tid_i,
    output logic             alloc_ack_o,
    output logic [1:0]       alloc_ack_tid_o,
    output logic [1:0]       alloc_way_o,
    output logic             alloc_err_o,
    output logic [NTHR-1:0]  rsv_busy_o
);
    logic [NTHR-1:0][NWAYS-1:0] blk;
    logic [NWAYS-1:0] blocked, cand, inv;
    logic [1:0]       way_sel;
    logic             found, accept;
    logic             ack_q, ack_d, err_q, err_d;
    logic [1:0]       ack_tid_q, ack_tid_d, way_q, way_d;

    assign accept = alloc_req_i &&
                    (!rsv_busy_o[alloc_tid_i] || (fill_done_i && (fill_tid_i == alloc_tid_i)));

    for (genvar t = 0; t < NTHR; t++) begin : g_rsv
        sparc_ifu_fill_waysel_rsv #(.IDX_W(IDX_W)) u_rsv (
            .clk       (clk),
            .reset     (reset),
            .set_i     (accept && (alloc_tid_i == 2'(t))),
            .clr_i     (fill_done_i && (fill_tid_i == 2'(t))),
            .set_idx_i (alloc_idx_i),
            .set_way_i (way_sel),
            .qry_en_i  (alloc_tid_i != 2'(t)),
            .qry_idx_i (alloc_idx_i),
            .busy_o    (rsv_busy_o[t]),
            .blk_o     (blk[t])
        );
    end

    always_comb begin
        blocked = '0;
        for (int t = 0; t < NTHR; t++) blocked = blocked | blk[t];
    end

    // At most three other threads exist, so at least one way is always a candidate.
    assign cand = ~blocked;
    assign inv  = cand & ~set_vld_i;

    always_comb begin
        way_sel = '0;
        found   = 1'b0;
        for (int w = 0; w < NWAYS; w++) begin
            if (!found && inv[w]) begin
                way_sel = 2'(w);
                found   = 1'b1;
            end
        end
        if (!found) begin
            if (cand[rand_way_i]) begin
                way_sel = rand_way_i;
            end else begin
                for (int w = NWAYS-1; w >= 0; w--)
                    if (cand[w]) way_sel = 2'(w);
            end
        end
    end

    // The random way counts as consumed whenever no invalid way was available,
    // even if the reservation check overrode it.
    assign lfsr_advance_o = accept && (inv == '0) && !reset;

    always_comb begin
        ack_d     = accept;
        err_d     = alloc_req_i && !accept;
        ack_tid_d = ack_tid_q;
        way_d     = way_q;
        if (accept) begin
            ack_tid_d = alloc_tid_i;
            way_d     = way_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ack_tid_q <= '0;
            way_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            err_q     <= err_d;
            ack_tid_q <= ack_tid_d;
            way_q     <= way_d;
        end
    end

    assign alloc_ack_o     = ack_q;
    assign alloc_err_o     = err_q;
    assign alloc_ack_tid_o = ack_tid_q;
    assign alloc_way_o     = way_q;
endmodule

// File: doc/sparc_ifu_fill_waysel.md
Name: sparc_ifu_fill_waysel

Overview:
- Icache fill-way allocator. It sits directly downstream of the IFU 5-bit replacement LFSR and consumes its 2-bit pseudo-random output.
- On each icache miss allocation it picks a victim way for the thread's pending fill:
  - an invalid way first;
  - otherwise the LFSR way;
  - never a way already reserved by another thread's outstanding fill to the same set.
- It holds per-thread reservations until the fill returns, and drives the LFSR advance input.

Parameters:
NTHR, 4, number of threads (tid width fixed at 2)
IDX_W, 7, icache set index width
NWAYS, 4, number of ways (fixed; matches the 2-bit random input)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
rand_way  in  2  pseudo-random way from the LFSR output
lfsr_advance  out  1  combinational; high when the random way was consumed this cycle
alloc_req  in  1  allocation request strobe (miss)
alloc_tid  in  2  requesting thread
alloc_idx  in  IDX_W  set index of the miss
set_vld  in  4  valid bits of the indexed set, same cycle as alloc_req
fill_done  in  1  fill complete strobe
fill_tid  in  2  thread whose fill completed
alloc_ack  out  1  registered; one-cycle pulse, allocation granted
alloc_ack_tid  out  2  registered; thread of the granted allocation
alloc_way  out  2  registered; chosen way
alloc_err  out  1  registered; one-cycle pulse, request from a thread already holding a reservation
rsv_busy  out  NTHR  registered; per-thread reservation valid

Behaviour:
- Reset: clk with asynchronous active-high reset; all state is cleared immediately on reset assertion.
  - Cleared: rsv_busy=0, all reserved idx/way fields=0, alloc_ack=0, alloc_ack_tid=0, alloc_way=0, alloc_err=0.
  - lfsr_advance=0 while reset is high.
  - Reset mid-operation drops all reservations; fills completing afterwards are ignored.
- Reservation table: per thread t, holds {busy, idx[IDX_W-1:0], way[1:0]}.
- Release: fill_done with rsv_busy[fill_tid]=1 clears busy at the next edge. fill_done for a non-busy tid is ignored (no error).
- Acceptance: alloc_req is accepted when rsv_busy[alloc_tid]=0, or when fill_done && fill_tid==alloc_tid in the same cycle (release then reallocate).
- Rejected request: alloc_err=1 next cycle, no ack, table unchanged, lfsr_advance=0.
- Blocked mask: for each way w, blocked[w]=1 if some thread u≠alloc_tid is busy with idx==alloc_idx and way==w.
  - A thread released by fill_done in the same cycle does not block.
- Candidates: cand = ~blocked. At most 3 other threads exist, so cand is never zero.
- Way selection (priority):
  1. lowest-index w with cand[w] && !set_vld[w];
  2. else rand_way if cand[rand_way];
  3. else lowest-index w with cand[w].
- lfsr_advance = accepted && no candidate invalid way. Asserted even when case 3 overrides the random pick.
- Latency: request in cycle N gives alloc_ack/alloc_way/alloc_ack_tid at N+1 and rsv_busy[tid]=1 at N+1.
  - Back-to-back requests every cycle are supported.
  - A request at N+1 sees the reservation made at N.
- Idle outputs: alloc_ack and alloc_err are single-cycle pulses. alloc_way and alloc_ack_tid hold their last value when idle.
- rand_way is sampled only in the request cycle. It is never registered internally.

Test Plan:
- Reset check: assert reset mid-reservation -> rsv_busy=0 and alloc_ack=0 immediately. lfsr_advance=0 while reset is high.
- Invalid-way priority: tid0, idx=0x05, set_vld=4'b1011, rand_way=0 -> next cycle alloc_ack=1, alloc_way=2, ack_tid=0, rsv_busy=4'b0001; lfsr_advance=0.
- Random path: tid1, idx=0x10, set_vld=4'b1111, rand_way=3, no other reservations -> alloc_way=3; lfsr_advance=1 in the request cycle.
- Reservation conflict:
  - tid0 holds idx 0x10 way3, tid2 holds idx 0x10 way0.
  - tid1 requests idx 0x10, set_vld=4'hF, rand_way=3 -> alloc_way=1, lfsr_advance=1.
  - Same request with idx=0x11 -> alloc_way=3.
- Duplicate/error: tid0 busy, tid0 requests again -> alloc_err pulse, no ack, rsv_busy unchanged. Repeat with fill_done, fill_tid=0 in the same cycle -> ack granted, rsv_busy[0] stays 1 with the new way.
- Same-cycle release unblock: tid2 holds idx 0x20 way1; fill_done tid2 and alloc tid3 idx 0x20, set_vld=4'hF, rand_way=1 in the same cycle -> alloc_way=1, rsv_busy=4'b1000.
